// File: rtl/reset_sequencer.sv
// Power-up / re-lock reset sequencer for the dot4x domain: qualifies clock lock,
// holds all resets for 2^HOLD_BITS cycles, then releases NUM_OUTS resets in a staggered order.
module reset_sequencer #(
  parameter int NUM_OUTS    = 3,
  parameter int HOLD_BITS   = 22,
  parameter int LOCK_FILTER = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic                clk_dot4x,
  input  logic                rst_n,
  input  logic                locked,
  input  logic                is_pal,
  input  logic                soft_rst_req,
  output logic [NUM_OUTS-1:0] rst,
  output logic                running,
  output logic [1:0]          chip
);

  localparam logic [1:0] CHIP6567R8 = 2'd0;
  localparam logic [1:0] CHIP6569   = 2'd1;

  localparam int HC_W  = HOLD_BITS + 1;
  localparam int IDX_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  localparam logic [HC_W-1:0]     HOLD_LAST = {1'b0, {HOLD_BITS{1'b1}}};
  localparam logic [7:0]          FILT_LAST = 8'(LOCK_FILTER - 1);
  localparam logic [7:0]          GAP_LAST  = 8'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_OUTS - 1);
  localparam logic [NUM_OUTS-1:0] ONE_HOT0  = NUM_OUTS'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [HC_W-1:0] sat_inc_hold(input logic [HC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic lock_p0, lock_s, pal_p0, pal_s;

  state_t              state, state_nx;
  logic [7:0]          filt_cnt, filt_nx;
  logic [HC_W-1:0]     hold_cnt, hold_nx;
  logic [7:0]          gap_cnt, gap_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [NUM_OUTS-1:0] rst_nx;
  logic                running_nx;
  logic [1:0]          chip_nx;
  logic                pal_latched, pal_lat_nx;
  logic                enter_hold;

  // Two-flop synchronisers for the asynchronous lock flag and chip strap
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
      pal_p0  <= 1'b0;
      pal_s   <= 1'b0;
    end else begin
      lock_p0 <= locked;
      lock_s  <= lock_p0;
      pal_p0  <= is_pal;
      pal_s   <= pal_p0;
    end
  end

  always_comb begin
    state_nx   = state;
    filt_nx    = filt_cnt;
    hold_nx    = hold_cnt;
    gap_nx     = gap_cnt;
    idx_nx     = idx;
    rst_nx     = rst;
    running_nx = running;
    chip_nx    = chip;
    pal_lat_nx = pal_latched;
    enter_hold = 1'b0;

    case (state)
      WAIT_LOCK: begin
        if (!lock_s) begin
          filt_nx = '0;
        end else begin
          filt_nx = sat_inc8(filt_cnt);
          if (filt_cnt == FILT_LAST) enter_hold = 1'b1;
        end
      end
      default: begin
        // Abort priority: lock loss, then soft request, then strap change
        if (!lock_s) begin
          state_nx   = WAIT_LOCK;
          filt_nx    = '0;
          rst_nx     = '1;
          running_nx = 1'b0;
        end else if (soft_rst_req || (pal_s != pal_latched)) begin
          enter_hold = 1'b1;
        end else begin
          case (state)
            HOLD: begin
              if (hold_cnt == HOLD_LAST) begin
                state_nx = RELEASE;
                idx_nx   = '0;
                gap_nx   = '0;
                rst_nx   = rst & ~ONE_HOT0;
              end else begin
                hold_nx = sat_inc_hold(hold_cnt);
              end
            end
            RELEASE: begin
              if (idx == IDX_LAST) begin
                state_nx   = RUN;
                running_nx = 1'b1;
              end else if (gap_cnt == GAP_LAST) begin
                rst_nx = rst & ~(ONE_HOT0 << (idx + 1'b1));
                idx_nx = idx + 1'b1;
                gap_nx = '0;
              end else begin
                gap_nx = sat_inc8(gap_cnt);
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    if (enter_hold) begin
      state_nx   = HOLD;
      hold_nx    = '0;
      chip_nx    = pal_s ? CHIP6569 : CHIP6567R8;
      pal_lat_nx = pal_s;
      rst_nx     = '1;
      running_nx = 1'b0;
    end
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_LOCK;
      filt_cnt    <= '0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      idx         <= '0;
      rst         <= '1;
      running     <= 1'b0;
      chip        <= CHIP6569;
      pal_latched <= 1'b1;
    end else begin
      state       <= state_nx;
      filt_cnt    <= filt_nx;
      hold_cnt    <= hold_nx;
      gap_cnt     <= gap_nx;
      idx         <= idx_nx;
      rst         <= rst_nx;
      running     <= running_nx;
      chip        <= chip_nx;
      pal_latched <= pal_lat_nx;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline model (cycles since hold entry) checked every cycle,
// plus directed scenarios with hand-computed edge expectations.
module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int HB = 4;
  localparam int LF = 3;
  localparam int G  = 2;
  localparam int H  = 1 << HB;

  logic         clk_dot4x = 1'b0;
  logic         rst_n = 1'b1;
  logic         locked = 1'b0;
  logic         is_pal = 1'b1;
  logic         soft_rst_req = 1'b0;
  logic [N-1:0] rst;
  logic         running;
  logic [1:0]   chip;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  reset_sequencer #(.NUM_OUTS(N), .HOLD_BITS(HB), .LOCK_FILTER(LF), .STAGE_GAP(G)) dut (
    .clk_dot4x(clk_dot4x), .rst_n(rst_n), .locked(locked), .is_pal(is_pal),
    .soft_rst_req(soft_rst_req), .rst(rst), .running(running), .chip(chip)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  // Model: either waiting for lock (consecutive count) or sequencing, with t = edges since hold entry
  logic m_s1, m_s2, m_p1, m_p2, m_seq, m_lat;
  int   m_cnt, m_t;
  logic [1:0] m_chip;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0;
    m_seq = 0; m_cnt = 0; m_t = 0; m_chip = 2'd1; m_lat = 1;
  endtask

  task automatic model_step();
    logic ls, ps;
    ls = m_s2;
    ps = m_p2;
    if (!m_seq) begin
      if (ls) begin
        m_cnt++;
        if (m_cnt == LF) begin
          m_seq = 1; m_t = 0; m_chip = ps ? 2'd1 : 2'd0; m_lat = ps;
        end
      end else begin
        m_cnt = 0;
      end
    end else if (!ls) begin
      m_seq = 0; m_cnt = 0;
    end else if (soft_rst_req || (ps != m_lat)) begin
      m_t = 0; m_chip = ps ? 2'd1 : 2'd0; m_lat = ps;
    end else if (m_t < 100000) begin
      m_t++;
    end
    m_s2 = m_s1; m_s1 = locked;
    m_p2 = m_p1; m_p1 = is_pal;
  endtask

  function automatic logic [N-1:0] model_rst();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = !(m_seq && (m_t >= H + k * G));
    return r;
  endfunction

  function automatic logic model_running();
    return m_seq && (m_t >= H + (N - 1) * G + 1);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk_dot4x or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_dot4x);
      #1;
      if (cmp_en) begin
        chk("model_rst", 32'(rst), 32'(model_rst()));
        chk("model_running", 32'(running), 32'(model_running()));
        chk("model_chip", 32'(chip), 32'(m_chip));
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk_dot4x);
      #2;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    locked = 1'b1;
    is_pal = 1'b1;
    ticks(2);
    chk("reset_rst", 32'(rst), 32'h7);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_chip", 32'(chip), 32'h1);
    rst_n = 1'b1;

    // Nominal power-up: edge 0 is the next rising edge
    for (int e = 0; e <= 25; e++) begin
      ticks(1);
      if (e == 19) chk("nom_rst_e19", 32'(rst), 32'h7);
      if (e == 20) chk("nom_rst_e20", 32'(rst), 32'h6);
      if (e == 21) chk("nom_rst_e21", 32'(rst), 32'h6);
      if (e == 22) chk("nom_rst_e22", 32'(rst), 32'h4);
      if (e == 24) chk("nom_rst_e24", 32'(rst), 32'h0);
      if (e == 24) chk("nom_run_e24", 32'(running), 32'h0);
      if (e == 25) chk("nom_run_e25", 32'(running), 32'h1);
      if (e == 25) chk("nom_chip", 32'(chip), 32'h1);
    end

    // Soft reset in RUN, sampled on edge n
    ticks(3);
    soft_rst_req = 1'b1;
    ticks(1);
    soft_rst_req = 1'b0;
    chk("soft_rst_n", 32'(rst), 32'h7);
    chk("soft_run_n", 32'(running), 32'h0);
    ticks(15);
    chk("soft_rst_n15", 32'(rst), 32'h7);
    ticks(1);
    chk("soft_rst_n16", 32'(rst), 32'h6);
    ticks(10);
    chk("soft_run_back", 32'(running), 32'h1);

    // Lock glitch during HOLD
    soft_rst_req = 1'b1;
    ticks(1);
    soft_rst_req = 1'b0;
    ticks(5);
    locked = 1'b0;
    ticks(1);
    locked = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      ticks(1);
      if (i == 1)  chk("hglitch_rst", 32'(rst), 32'h7);
      if (i == 19) chk("hglitch_rst_r19", 32'(rst), 32'h7);
      if (i == 20) chk("hglitch_rst_r20", 32'(rst), 32'h6);
    end

    // Lock glitch in RUN: outputs forced within 3 edges
    ticks(6);
    chk("rglitch_pre_run", 32'(running), 32'h1);
    locked = 1'b0;
    ticks(1);
    locked = 1'b1;
    ticks(2);
    chk("rglitch_rst", 32'(rst), 32'h7);
    chk("rglitch_run", 32'(running), 32'h0);

    // Lock filter: 1,1,0 pattern never qualifies
    locked = 1'b0;
    ticks(2);
    for (int i = 0; i < 30; i++) begin
      locked = (i % 3) != 2;
      ticks(1);
      chk("filter_rst", 32'(rst), 32'h7);
    end

    // Strap change in RUN
    locked = 1'b1;
    ticks(30);
    chk("strap_pre_run", 32'(running), 32'h1);
    chk("strap_pre_chip", 32'(chip), 32'h1);
    is_pal = 1'b0;
    ticks(3);
    chk("strap_rst", 32'(rst), 32'h7);
    chk("strap_chip", 32'(chip), 32'h0);
    ticks(15);
    chk("strap_rst_h15", 32'(rst), 32'h7);
    ticks(1);
    chk("strap_rst_h16", 32'(rst), 32'h6);
    ticks(6);
    chk("strap_run", 32'(running), 32'h1);
    chk("strap_run_chip", 32'(chip), 32'h0);

    // Strap flip and lock loss on the same cycle: lock loss wins, chip unchanged
    is_pal = 1'b1;
    locked = 1'b0;
    ticks(3);
    chk("both_rst", 32'(rst), 32'h7);
    chk("both_run", 32'(running), 32'h0);
    chk("both_chip", 32'(chip), 32'h0);
    locked = 1'b1;
    ticks(30);
    chk("both_relock_run", 32'(running), 32'h1);
    chk("both_relock_chip", 32'(chip), 32'h1);

    // Async reset mid-RELEASE
    is_pal = 1'b0;
    ticks(26);
    chk("async_pre_chip", 32'(chip), 32'h0);
    soft_rst_req = 1'b1;
    ticks(1);
    soft_rst_req = 1'b0;
    ticks(16);
    chk("async_pre_rst", 32'(rst), 32'h6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(rst), 32'h7);
    chk("async_run", 32'(running), 32'h0);
    chk("async_chip", 32'(chip), 32'h1);
    ticks(1);
    rst_n = 1'b1;
    ticks(30);
    chk("async_restart_run", 32'(running), 32'h1);
    chk("async_restart_chip", 32'(chip), 32'h0);

    // Randomised abort mix against the model
    for (int i = 0; i < 4000; i++) begin
      ticks(1);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      if (!locked) locked = ($urandom_range(0, 3) != 0);
      else locked = ($urandom_range(0, 99) != 0);
      soft_rst_req = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) is_pal = ~is_pal;
    end
    soft_rst_req = 1'b0;
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
